weight_fetch_ctrl: RTL
======================

Name: weight_fetch_ctrl

Overview:
Sequencer for one neuron's weight memory (registered read, 1-cycle latency, output holds while ren low). On start it walks addresses 0..numInputs-1. Each weight read is paired with one accepted input sample. The aligned {x, w} pair goes to the neuron MAC over a valid/ready handshake, and done pulses after the last pair is accepted.

Parameters:
numInputs, 784, inputs per neuron (weights per pass)
addrWidth, 10, weight memory address width; must satisfy 2**addrWidth > numInputs
dataWidth, 16, width of input samples and weights

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin a pass; sampled only in IDLE
busy  output  1  high from the cycle after start until done
done  output  1  one-cycle pulse after last pair accepted
in_valid  input  1  input sample valid
in_data  input  dataWidth  input sample
in_ready  output  1  sample accepted this cycle (combinational)
wmem_ren  output  1  weight memory read enable (combinational, equals in_ready)
wmem_raddr  output  addrWidth  weight memory read address (registered counter)
wmem_wout  input  dataWidth  weight memory read data
mac_valid  output  1  pair valid
mac_x  output  dataWidth  registered sample aligned with mac_w
mac_w  output  dataWidth  weight, wired straight from wmem_wout
mac_last  output  1  marks the final pair of a pass
mac_ready  input  1  MAC accepts pair

Behaviour:
- Reset values: busy=0, done=0, mac_valid=0, mac_last=0, mac_x=0, wmem_raddr=0, state=IDLE.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 clears the address counter to 0 and goes to RUN. The issue count is addrWidth+1 bits.
  - in_ready=0 in IDLE.
- RUN:
  - issue = in_valid & (!mac_valid | mac_ready).
  - in_ready = wmem_ren = issue.
- On issue:
  - mac_x <= in_data.
  - raddr increments.
  - mac_valid <= 1 next cycle.
  - mac_last <= (raddr == numInputs-1).
  - If this was the final address, go to DRAIN.
- If mac_valid & mac_ready & !issue, then mac_valid <= 0.
- mac_w/mac_x alignment: the weight appears on wmem_wout exactly one cycle after ren, together with the registered mac_x. No skid buffer is needed because the memory holds its output while ren=0. The controller must never assert ren while a pair is valid and not accepted.
- Throughput: one pair per cycle with in_valid and mac_ready held high. A full pass takes numInputs+1 cycles from the first issue to the last pair being valid.
- DRAIN:
  - No issue.
  - When mac_valid & mac_ready & mac_last, clear mac_valid and go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, back to IDLE.
  - start is ignored in the DONE cycle.
- start is ignored outside IDLE.
- busy=1 in RUN and DRAIN.
- Backpressure:
  - mac_ready=0 with mac_valid=1 freezes mac_x, mac_w and raddr.
  - in_ready is held at 0.
- Reset mid-pass: asynchronous return to reset values. No partial done.
- numInputs=1: first issue goes straight to DRAIN with mac_last=1.

Optional Feature:
Macro WFC_BIAS_EN.
- Defined:
  - After the last weight is issued, the controller reads address numInputs (the bias word) in state BIAS.
  - BIAS asserts wmem_ren when !mac_valid | mac_ready. No input sample is consumed; in_ready=0.
  - The next pair carries mac_x=0, the bias on mac_w, and new output mac_bias=1.
  - mac_last moves to the bias pair.
  - Memory depth must be numInputs+1.
- Undefined:
  - No BIAS state and no mac_bias port.
  - mac_last is on the last weight pair.

Decomposition:
- Shared package nn_pkg: state enum wfc_state_t (IDLE, RUN, DRAIN, DONE, BIAS), default dataWidth/addrWidth constants, numInputs default 784.
- No sub-module is needed; a single flat module is natural.
- The testbench instantiates weight_mem alongside the controller.

Test Plan:
- Reset, start, numInputs=4, in_valid and mac_ready always high:
  - raddr goes 0,1,2,3 on consecutive cycles.
  - mac_w values equal mem[0..3]; mac_x equals the samples 0x0011..0x0014.
  - mac_last on the 4th pair; done one cycle after it; 5 cycles from first issue to the last pair.
- mac_ready low 3 cycles while pair 2 is valid:
  - mac_x, mac_w and raddr are frozen; in_ready=0.
  - Resumes with no lost or duplicated pair; 4 pairs total.
- in_valid gaps (1,0,0,1,1,0,1): exactly 4 issues; pairs stay aligned with sample values.
- start pulsed during RUN and in the DONE cycle: no effect. A second start in IDLE restarts from address 0.
- Reset asserted after the 2nd issue: all outputs return to reset values in the same cycle, no done. A subsequent pass is correct.
- With WFC_BIAS_EN, numInputs=4, mem[4]=0x0100: 5th pair has mac_bias=1, mac_x=0, mac_w=0x0100 and mac_last=1; only 4 samples consumed.

Source files
------------

// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared defaults and weight-fetch FSM state encoding
package nn_pkg;
  localparam int NUM_INPUTS_DEF = 784;
  localparam int ADDR_WIDTH_DEF = 10;
  localparam int DATA_WIDTH_DEF = 16;

  typedef enum logic [2:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE,
    BIAS
  } wfc_state_t;
endpackage

// File: rtl/weight_mem.sv
// rtl/weight_mem.sv - single-port weight store, registered read that holds while ren is low
module weight_mem #(
  parameter int addrWidth = 10,
  parameter int dataWidth = 16
) (
  input  logic                 i_clk,
  input  logic                 i_wen,
  input  logic [addrWidth-1:0] i_waddr,
  input  logic [dataWidth-1:0] i_wdata,
  input  logic                 i_ren,
  input  logic [addrWidth-1:0] i_raddr,
  output logic [dataWidth-1:0] o_rdata
);
  logic [dataWidth-1:0] r_mem [2**addrWidth];
  logic [dataWidth-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_wen) r_mem[i_waddr] <= i_wdata;
    if (i_ren) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/weight_fetch_ctrl.sv
// rtl/weight_fetch_ctrl.sv - walks one neuron's weights and pairs each with an input sample
// WFC_BIAS_EN: append a bias pair (address numInputs, mac_x=0, mac_bias=1) to every pass
module weight_fetch_ctrl
  import nn_pkg::*;
#(
  parameter int numInputs = NUM_INPUTS_DEF,
  parameter int addrWidth = ADDR_WIDTH_DEF,
  parameter int dataWidth = DATA_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  input  logic                 in_valid,
  input  logic [dataWidth-1:0] in_data,
  output logic                 in_ready,
  output logic                 wmem_ren,
  output logic [addrWidth-1:0] wmem_raddr,
  input  logic [dataWidth-1:0] wmem_wout,
  output logic                 mac_valid,
  output logic [dataWidth-1:0] mac_x,
  output logic [dataWidth-1:0] mac_w,
  output logic                 mac_last,
`ifdef WFC_BIAS_EN
  output logic                 mac_bias,
`endif
  input  logic                 mac_ready
);
  localparam logic [addrWidth-1:0] LAST_ADDR = addrWidth'(numInputs - 1);

  wfc_state_t           r_state;
  wfc_state_t           w_state_nxt;
  logic                 r_mac_valid;
  logic                 r_mac_last;
  logic [dataWidth-1:0] r_mac_x;
  logic [addrWidth-1:0] r_raddr;
  logic                 w_slot_free;
  logic                 w_final;
  logic                 w_issue;
  logic                 w_bias_issue;
`ifdef WFC_BIAS_EN
  logic                 r_mac_bias;
`endif

  // A read may only be launched when the pair register can take its result next cycle.
  assign w_slot_free = !r_mac_valid || mac_ready;
  assign w_final     = (r_raddr == LAST_ADDR);

  always_comb begin
    w_state_nxt  = r_state;
    w_issue      = 1'b0;
    w_bias_issue = 1'b0;
    case (r_state)
      IDLE: if (start) w_state_nxt = RUN;
      RUN: begin
        w_issue = in_valid && w_slot_free;
        if (w_issue && w_final) begin
`ifdef WFC_BIAS_EN
          w_state_nxt = BIAS;
`else
          w_state_nxt = DRAIN;
`endif
        end
      end
`ifdef WFC_BIAS_EN
      BIAS: begin
        w_bias_issue = w_slot_free;
        if (w_bias_issue) w_state_nxt = DRAIN;
      end
`endif
      DRAIN: if (r_mac_valid && mac_ready && r_mac_last) w_state_nxt = DONE;
      DONE:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_raddr     <= '0;
      r_mac_valid <= 1'b0;
      r_mac_last  <= 1'b0;
      r_mac_x     <= '0;
`ifdef WFC_BIAS_EN
      r_mac_bias  <= 1'b0;
`endif
    end else begin
      if (r_state == IDLE && start) r_raddr <= '0;
      else if (w_issue || w_bias_issue) r_raddr <= r_raddr + addrWidth'(1);

      if (w_issue) begin
        r_mac_valid <= 1'b1;
        r_mac_x     <= in_data;
`ifdef WFC_BIAS_EN
        r_mac_last  <= 1'b0;
        r_mac_bias  <= 1'b0;
      end else if (w_bias_issue) begin
        r_mac_valid <= 1'b1;
        r_mac_x     <= '0;
        r_mac_last  <= 1'b1;
        r_mac_bias  <= 1'b1;
`else
        r_mac_last  <= w_final;
`endif
      end else if (r_mac_valid && mac_ready) begin
        r_mac_valid <= 1'b0;
      end
    end
  end

  assign in_ready   = w_issue;
  assign wmem_ren   = w_issue || w_bias_issue;
  assign wmem_raddr = r_raddr;
  assign busy       = (r_state == RUN) || (r_state == DRAIN) || (r_state == BIAS);
  assign done       = (r_state == DONE);
  assign mac_valid  = r_mac_valid;
  assign mac_x      = r_mac_x;
  assign mac_w      = wmem_wout;
  assign mac_last   = r_mac_last;
`ifdef WFC_BIAS_EN
  assign mac_bias   = r_mac_bias;
`endif
endmodule
